regfile_mp: RTL and testbench

//  Parametrised multi-read-port, single-write-port register file for the MIPS datapath core.

---
 rtl/regfile_pkg.sv | 19 +
 rtl/regfile_sweep_fsm.sv | 59 +++++
 rtl/regfile_mp.sv | 104 ++++++++++
 tb/tb_regfile_mp.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and port-slicing helpers for the multi-port register file.
package regfile_pkg;

  typedef enum logic {
    SWEEP = 1'b0,
    RUN   = 1'b1
  } state_e;

  // Bit offset of read port p inside the flattened address bus.
  function automatic int unsigned addr_slice(input int unsigned p, input int unsigned addr_w);
    return p * addr_w;
  endfunction

  // Bit offset of read port p inside the flattened data bus.
  function automatic int unsigned data_slice(input int unsigned p, input int unsigned data_w);
    return p * data_w;
  endfunction

endpackage

// File: rtl/regfile_sweep_fsm.sv
// Clear-sweep controller: walks every entry once after reset or on clr_req.
module regfile_sweep_fsm
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clr_req,
  output logic              busy,
  output logic              sweep_we,
  output logic [ADDR_W-1:0] sweep_addr
);

  localparam int unsigned      CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'((1 << ADDR_W) - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= SWEEP;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      SWEEP: begin
        // clr_req is deliberately not looked at here: no restart mid-sweep
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (clr_req) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
    endcase
    busy_d = (state_d == SWEEP);
  end

  assign busy       = busy_q;
  assign sweep_we   = (state_q == SWEEP);
  assign sweep_addr = cnt_q[ADDR_W-1:0];

endmodule

// File: rtl/regfile_mp.sv
// Multi-read, single-write register file with registered reads, optional
// write-to-read bypass, optional hardwired-zero entry and a clear sweep.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned N_RD     = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clr_req,
  output logic                     busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [N_RD-1:0]          rd_en,
  input  logic [N_RD*ADDR_W-1:0]   rd_addr,
  output logic [N_RD*DATA_W-1:0]   rd_data,
  output logic [N_RD-1:0]          rd_valid
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic              sweep_we;
  logic [ADDR_W-1:0] sweep_addr;

  regfile_sweep_fsm #(
    .ADDR_W (ADDR_W)
  ) u_sweep (
    .clock      (clock),
    .reset      (reset),
    .clr_req    (clr_req),
    .busy       (busy),
    .sweep_we   (sweep_we),
    .sweep_addr (sweep_addr)
  );

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              usr_we;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // Write mux: the sweep owns the array while it runs; user writes are lost.
  always_comb begin
    usr_we    = wr_en & ~sweep_we;
    mem_we    = sweep_we | usr_we;
    mem_waddr = sweep_we ? sweep_addr : wr_addr;
    mem_wdata = sweep_we ? '0 : wr_data;
    if ((ZERO_REG != 0) && (mem_waddr == '0)) begin
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  logic [N_RD*DATA_W-1:0] rd_data_q, rd_data_d;
  logic [N_RD-1:0]        rd_valid_q, rd_valid_d;
  logic [ADDR_W-1:0]      ra;
  logic [DATA_W-1:0]      rval;

  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = '0;
    ra         = '0;
    rval       = '0;
    for (int unsigned p = 0; p < N_RD; p++) begin
      ra = rd_addr[addr_slice(p, ADDR_W) +: ADDR_W];
      if (rd_en[p] && !sweep_we) begin
        rd_valid_d[p] = 1'b1;
        if ((ZERO_REG != 0) && (ra == '0)) begin
          rval = '0;
        end else if ((BYPASS != 0) && usr_we && (wr_addr == ra)) begin
          rval = wr_data;
        end else begin
          rval = mem_q[ra];
        end
        rd_data_d[data_slice(p, DATA_W) +: DATA_W] = rval;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= '0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: reads push expected data, a monitor pops on rd_valid.
module tb_regfile_mp;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned N_RD   = 2;
  localparam int unsigned DEPTH  = 32;
  localparam int unsigned ZREG   = 1;
  localparam int unsigned BYP    = 1;

  logic                   clock   = 1'b0;
  logic                   reset   = 1'b1;
  logic                   clr_req = 1'b0;
  logic                   busy;
  logic                   wr_en   = 1'b0;
  logic [ADDR_W-1:0]      wr_addr = '0;
  logic [DATA_W-1:0]      wr_data = '0;
  logic [N_RD-1:0]        rd_en   = '0;
  logic [N_RD*ADDR_W-1:0] rd_addr = '0;
  logic [N_RD*DATA_W-1:0] rd_data;
  logic [N_RD-1:0]        rd_valid;

  always #5 clock = ~clock;

  regfile_mp #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .N_RD     (N_RD),
    .ZERO_REG (ZREG),
    .BYPASS   (BYP)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .clr_req  (clr_req),
    .busy     (busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [DATA_W-1:0] model [DEPTH];
  logic [DATA_W-1:0] exp_q [N_RD][$];

  task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] exp_read(input logic [ADDR_W-1:0] a, input logic we,
                                                 input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd);
    if (ZREG != 0 && a == '0) return '0;
    if (BYP != 0 && we && wa == a) return wd;
    return model[a];
  endfunction

  // Every valid read must match the oldest outstanding expectation for its port.
  always @(negedge clock) begin
    for (int p = 0; p < N_RD; p++) begin
      if (rd_valid[p] === 1'b1) begin
        if (exp_q[p].size() == 0) begin
          check($sformatf("spurious_valid_p%0d", p), DATA_W'(rd_valid[p]), '0);
        end else begin
          check($sformatf("rd_data_p%0d", p), rd_data[p*DATA_W +: DATA_W], exp_q[p].pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic we, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                       input logic [N_RD-1:0] ren, input logic [ADDR_W-1:0] ra0, input logic [ADDR_W-1:0] ra1);
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    rd_en   = ren;
    rd_addr = {ra1, ra0};
    if (ren[0]) exp_q[0].push_back(exp_read(ra0, we, wa, wd));
    if (ren[1]) exp_q[1].push_back(exp_read(ra1, we, wa, wd));
    if (we && !(ZREG != 0 && wa == '0)) model[wa] = wd;
    step();
    wr_en = 1'b0;
    rd_en = '0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b0, '0, '0, 2'b11, ADDR_W'(a), ADDR_W'(DEPTH - 1 - a));
    end
    step();
  endtask

  // Counts busy cycles sampled on falling edges; bounded so a stuck busy cannot hang the run.
  task automatic wait_busy(input string tag, input int exp_n);
    int n;
    n = 0;
    while (n < 200) begin
      @(negedge clock);
      if (busy !== 1'b1) break;
      n++;
    end
    check(tag, DATA_W'(n), DATA_W'(exp_n));
  endtask

  initial begin
    clear_model();

    // 1: reset state, sweep length, everything reads zero
    @(negedge clock);
    check("reset_busy", DATA_W'(busy), 32'd1);
    check("reset_valid", DATA_W'(rd_valid), '0);
    check("reset_data_p0", rd_data[0 +: DATA_W], '0);
    check("reset_data_p1", rd_data[DATA_W +: DATA_W], '0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    wait_busy("busy_after_reset", 32);
    read_all();

    // 2: write then read on both ports
    drive(1'b1, 5'd10, 32'hDEAD_BEEF, 2'b00, '0, '0);
    drive(1'b0, '0, '0, 2'b11, 5'd10, 5'd10);

    // 3: same-cycle write/read of addr 17
    drive(1'b1, 5'd17, 32'h5, 2'b11, 5'd17, 5'd17);
    drive(1'b0, '0, '0, 2'b11, 5'd17, 5'd10);

    // 4: write to entry 0
    drive(1'b1, 5'd0, 32'h1234, 2'b00, '0, '0);
    drive(1'b0, '0, '0, 2'b11, 5'd0, 5'd0);
    drive(1'b1, 5'd0, 32'h4321, 2'b11, 5'd0, 5'd17);

    // 5: clear sweep with a lost write and an ignored second clr_req
    drive(1'b1, 5'd18, 32'h1818_1818, 2'b00, '0, '0);
    drive(1'b1, 5'd19, 32'h1919_1919, 2'b00, '0, '0);
    drive(1'b0, '0, '0, 2'b11, 5'd18, 5'd19);
    step();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    clear_model();
    fork
      wait_busy("busy_clr", 32);
      begin
        wr_en   = 1'b1;
        wr_addr = 5'd18;
        wr_data = 32'h7;
        rd_en   = 2'b11;
        rd_addr = {5'd19, 5'd18};
        repeat (3) step();
        wr_en = 1'b0;
        rd_en = '0;
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
      end
    join
    read_all();

    // 6: reset mid-sweep clears rd_data asynchronously and restarts the sweep
    drive(1'b1, 5'd3, 32'hA5A5_A5A5, 2'b00, '0, '0);
    drive(1'b0, '0, '0, 2'b11, 5'd3, 5'd3);
    step();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (10) step();
    @(negedge clock);
    #1;
    reset = 1'b1;
    #1;
    check("async_rst_data_p0", rd_data[0 +: DATA_W], '0);
    check("async_rst_data_p1", rd_data[DATA_W +: DATA_W], '0);
    check("async_rst_valid", DATA_W'(rd_valid), '0);
    check("async_rst_busy", DATA_W'(busy), 32'd1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    clear_model();
    wait_busy("busy_reset_mid", 32);
    read_all();

    step();
    check("drain_p0", DATA_W'(exp_q[0].size()), '0);
    check("drain_p1", DATA_W'(exp_q[1].size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
